// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_store_unit_pkg : shared width codes, causes and FSM encoding     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package load_store_unit_pkg;

    localparam int LSU_XLEN = 32;
    localparam int LSU_RD_W = 5;

    localparam logic [2:0] LSU_F3_LB  = 3'b000;
    localparam logic [2:0] LSU_F3_LH  = 3'b001;
    localparam logic [2:0] LSU_F3_LW  = 3'b010;
    localparam logic [2:0] LSU_F3_LBU = 3'b100;
    localparam logic [2:0] LSU_F3_LHU = 3'b101;

    localparam logic [1:0] LSU_EXC_LMIS = 2'd0;
    localparam logic [1:0] LSU_EXC_SMIS = 2'd1;
    localparam logic [1:0] LSU_EXC_ILL  = 2'd2;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_e;

    function automatic logic lsu_f3_illegal(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_store_unit_if : execute, data-memory and writeback bundle        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface load_store_unit_if #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
);
    logic            ex_valid;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_addr;
    logic [XLEN-1:0] ex_wdata;
    logic [RD_W-1:0] ex_rd;
    logic            dm_ack;
    logic [XLEN-1:0] dm_rdata;
    logic            dm_req;
    logic            dm_we;
    logic [XLEN-1:0] dm_addr;
    logic [3:0]      dm_be;
    logic [XLEN-1:0] dm_wdata;
    logic            lsu_busy;
    logic            wb_valid;
    logic [RD_W-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            exc;
    logic [1:0]      exc_cause;
    logic [XLEN-1:0] exc_addr;

    // The LSU side: masters the data-memory bus.
    modport master (
        input  ex_valid, ex_mem_read, ex_mem_write, ex_funct3, ex_addr,
               ex_wdata, ex_rd, dm_ack, dm_rdata,
        output dm_req, dm_we, dm_addr, dm_be, dm_wdata, lsu_busy,
               wb_valid, wb_rd, wb_data, exc, exc_cause, exc_addr
    );

    modport slave (
        output ex_valid, ex_mem_read, ex_mem_write, ex_funct3, ex_addr,
               ex_wdata, ex_rd, dm_ack, dm_rdata,
        input  dm_req, dm_we, dm_addr, dm_be, dm_wdata, lsu_busy,
               wb_valid, wb_rd, wb_data, exc, exc_cause, exc_addr
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit_load_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_load_align : selects and sign/zero-extends load data              |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module lsu_load_align
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic [XLEN-1:0] rdata_i,
    input  wire logic [2:0]      funct3_i,
    input  wire logic [1:0]      off_i,
    output logic      [XLEN-1:0] data_o
);
    logic [7:0]  byte_w;
    logic [15:0] half_w;

    assign byte_w = rdata_i[{off_i, 3'b000} +: 8];
    assign half_w = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        data_o = rdata_i;
        case (funct3_i)
            LSU_F3_LB:  data_o = {{(XLEN-8){byte_w[7]}}, byte_w};
            LSU_F3_LH:  data_o = {{(XLEN-16){half_w[15]}}, half_w};
            LSU_F3_LBU: data_o = {{(XLEN-8){1'b0}}, byte_w};
            LSU_F3_LHU: data_o = {{(XLEN-16){1'b0}}, half_w};
            default:    data_o = rdata_i;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_store_unit : memory stage with req/ack bus, lane alignment       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = LSU_XLEN,
    parameter int RD_W = LSU_RD_W
) (
    input  wire logic       clk,
    input  wire logic       rstn,
    load_store_unit_if.master bus
);
    lsu_state_e      state_q;
    logic            dm_req_q;
    logic            dm_we_q;
    logic [XLEN-1:0] dm_addr_q;
    logic [3:0]      dm_be_q;
    logic [XLEN-1:0] dm_wdata_q;
    logic            wb_valid_q;
    logic [RD_W-1:0] wb_rd_q;
    logic [XLEN-1:0] wb_data_q;
    logic            exc_q;
    logic [1:0]      exc_cause_q;
    logic [XLEN-1:0] exc_addr_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;

    logic            one_op;
    logic            both_op;
    logic            f3_bad;
    logic            is_ill;
    logic            is_mis;
    logic            is_go;
    logic [3:0]      be_d;
    logic [XLEN-1:0] wdata_d;
    logic [XLEN-1:0] load_data_d;

    assign one_op  = bus.ex_valid && (bus.ex_mem_read ^ bus.ex_mem_write);
    assign both_op = bus.ex_valid && bus.ex_mem_read && bus.ex_mem_write;
    assign f3_bad  = lsu_f3_illegal(bus.ex_funct3);
    assign is_ill  = both_op || (one_op && f3_bad);
    assign is_mis  = one_op && !f3_bad &&
                     (((bus.ex_funct3[1:0] == 2'b01) && bus.ex_addr[0]) ||
                      ((bus.ex_funct3[1:0] == 2'b10) && (bus.ex_addr[1:0] != 2'b00)));
    assign is_go   = one_op && !f3_bad && !is_mis;

    // Store lanes follow funct3[1:0]; loads always fetch the full word.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = bus.ex_wdata;
        if (bus.ex_mem_write) begin
            case (bus.ex_funct3[1:0])
                2'b00: begin
                    be_d    = 4'b0001 << bus.ex_addr[1:0];
                    wdata_d = {4{bus.ex_wdata[7:0]}};
                end
                2'b01: begin
                    be_d    = 4'b0011 << bus.ex_addr[1:0];
                    wdata_d = {2{bus.ex_wdata[15:0]}};
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = bus.ex_wdata;
                end
            endcase
        end
    end

    lsu_load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .rdata_i (bus.dm_rdata),
        .funct3_i(f3_q),
        .off_i   (off_q),
        .data_o  (load_data_d)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= LSU_IDLE;
            dm_req_q    <= 1'b0;
            dm_we_q     <= 1'b0;
            dm_addr_q   <= '0;
            dm_be_q     <= '0;
            dm_wdata_q  <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            exc_q       <= 1'b0;
            exc_cause_q <= '0;
            exc_addr_q  <= '0;
            f3_q        <= '0;
            off_q       <= '0;
        end else begin
            exc_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            case (state_q)
                LSU_IDLE: begin
                    if (is_ill || is_mis) begin
                        exc_q       <= 1'b1;
                        exc_addr_q  <= bus.ex_addr;
                        exc_cause_q <= is_ill ? LSU_EXC_ILL :
                                       (bus.ex_mem_write ? LSU_EXC_SMIS : LSU_EXC_LMIS);
                    end else if (is_go) begin
                        state_q    <= LSU_REQ;
                        dm_req_q   <= 1'b1;
                        dm_we_q    <= bus.ex_mem_write;
                        dm_addr_q  <= {bus.ex_addr[XLEN-1:2], 2'b00};
                        dm_be_q    <= be_d;
                        dm_wdata_q <= wdata_d;
                        wb_rd_q    <= bus.ex_rd;
                        f3_q       <= bus.ex_funct3;
                        off_q      <= bus.ex_addr[1:0];
                    end
                end
                LSU_REQ: begin
                    if (bus.dm_ack) begin
                        dm_req_q <= 1'b0;
                        dm_we_q  <= 1'b0;
                        if (dm_we_q) begin
                            state_q <= LSU_IDLE;
                        end else begin
                            wb_data_q  <= load_data_d;
                            wb_valid_q <= 1'b1;
                            state_q    <= LSU_DONE;
                        end
                    end
                end
                LSU_DONE: state_q <= LSU_IDLE;
                default:  state_q <= LSU_IDLE;
            endcase
        end
    end

    assign bus.lsu_busy  = (state_q != LSU_IDLE);
    assign bus.dm_req    = dm_req_q;
    assign bus.dm_we     = dm_we_q;
    assign bus.dm_addr   = dm_addr_q;
    assign bus.dm_be     = dm_be_q;
    assign bus.dm_wdata  = dm_wdata_q;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.exc       = exc_q;
    assign bus.exc_cause = exc_cause_q;
    assign bus.exc_addr  = exc_addr_q;
endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_load_store_unit : randomized bench against a behavioural model     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_load_store_unit;
    logic clk;
    logic rstn;
    int   n_assert;
    int   n_fail;

    load_store_unit_if #(.XLEN(32), .RD_W(5)) bus ();

    load_store_unit #(.XLEN(32), .RD_W(5)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference extension computed arithmetically from the width code.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        logic [31:0] v;
        v = rdata >> (8 * (addr % 4));
        case (f3)
            3'd0: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            3'd1: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            3'd4: v = v % 256;
            3'd5: v = v % 65536;
            default: v = rdata;
        endcase
        return v;
    endfunction

    task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rdst, input int lat, input logic [31:0] rdata);
        int          sz;
        bit          ill;
        bit          mis;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        ill = (rd && wr) || (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        mis = !ill && ((addr % sz) != 0);
        exp_be = wr ? 4'(((1 << sz) - 1) << (addr % 4)) : 4'hF;
        exp_wd = (sz == 1) ? (wdata % 256) * 32'h01010101 :
                 (sz == 2) ? (wdata % 65536) * 32'h00010001 : wdata;

        @(negedge clk);
        bus.dm_ack = 1'b0;
        bus.ex_valid = 1'b1;
        bus.ex_mem_read = rd;
        bus.ex_mem_write = wr;
        bus.ex_funct3 = f3;
        bus.ex_addr = addr;
        bus.ex_wdata = wdata;
        bus.ex_rd = rdst;
        @(negedge clk);
        if (!rd && !wr) begin
            bus.ex_valid = 1'b0;
            check("noop_busy", 32'(bus.lsu_busy), 0);
            check("noop_exc", 32'(bus.exc), 0);
            return;
        end
        if (ill || mis) begin
            bus.ex_valid = 1'b0;
            check("exc", 32'(bus.exc), 1);
            check("exc_cause", 32'(bus.exc_cause), ill ? 2 : (wr ? 1 : 0));
            check("exc_addr", bus.exc_addr, addr);
            check("exc_busy", 32'(bus.lsu_busy), 0);
            check("exc_req", 32'(bus.dm_req), 0);
            @(negedge clk);
            check("exc_drop", 32'(bus.exc), 0);
            check("exc_req2", 32'(bus.dm_req), 0);
            return;
        end
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) @(negedge clk);
            check("req_busy", 32'(bus.lsu_busy), 1);
            check("req", 32'(bus.dm_req), 1);
            check("req_we", 32'(bus.dm_we), 32'(wr));
            check("req_addr", bus.dm_addr, addr & 32'hFFFF_FFFC);
            check("req_be", 32'(bus.dm_be), 32'(exp_be));
            if (wr) check("req_wdata", bus.dm_wdata, exp_wd);
            check("req_wbv", 32'(bus.wb_valid), 0);
            bus.ex_valid = 1'($urandom_range(0, 1));
            bus.dm_ack = (k == lat);
            bus.dm_rdata = (k == lat) ? rdata : $urandom;
        end
        @(negedge clk);
        bus.dm_ack = 1'b0;
        bus.ex_valid = 1'b0;
        check("ack_req", 32'(bus.dm_req), 0);
        if (wr) begin
            check("st_busy", 32'(bus.lsu_busy), 0);
            check("st_wbv", 32'(bus.wb_valid), 0);
        end else begin
            check("ld_busy", 32'(bus.lsu_busy), 1);
            check("ld_wbv", 32'(bus.wb_valid), 1);
            check("ld_data", bus.wb_data, ref_load(f3, addr, rdata));
            check("ld_rd", 32'(bus.wb_rd), 32'(rdst));
            @(negedge clk);
            check("ld_wbv_drop", 32'(bus.wb_valid), 0);
            check("ld_idle", 32'(bus.lsu_busy), 0);
        end
    endtask

    task automatic idle_ack();
        @(negedge clk);
        bus.ex_valid = 1'b0;
        bus.dm_ack = 1'b1;
        bus.dm_rdata = $urandom;
        @(negedge clk);
        bus.dm_ack = 1'b0;
        check("spur_busy", 32'(bus.lsu_busy), 0);
        check("spur_wbv", 32'(bus.wb_valid), 0);
        check("spur_req", 32'(bus.dm_req), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, 32'(bus.dm_req), 0);
        check({tag, "_we"}, 32'(bus.dm_we), 0);
        check({tag, "_addr"}, bus.dm_addr, 0);
        check({tag, "_be"}, 32'(bus.dm_be), 0);
        check({tag, "_wdata"}, bus.dm_wdata, 0);
        check({tag, "_busy"}, 32'(bus.lsu_busy), 0);
        check({tag, "_wbv"}, 32'(bus.wb_valid), 0);
        check({tag, "_wbrd"}, 32'(bus.wb_rd), 0);
        check({tag, "_wbdata"}, bus.wb_data, 0);
        check({tag, "_exc"}, 32'(bus.exc), 0);
        check({tag, "_cause"}, 32'(bus.exc_cause), 0);
        check({tag, "_excaddr"}, bus.exc_addr, 0);
    endtask

    initial begin
        n_assert = 0;
        n_fail = 0;
        rstn = 1'b0;
        bus.ex_valid = 1'b0;
        bus.ex_mem_read = 1'b0;
        bus.ex_mem_write = 1'b0;
        bus.ex_funct3 = 3'd0;
        bus.ex_addr = '0;
        bus.ex_wdata = '0;
        bus.ex_rd = '0;
        bus.dm_ack = 1'b0;
        bus.dm_rdata = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rstn = 1'b1;

        run_op(0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 5'd0, 3, 32'h0);
        run_op(0, 1, 3'd0, 32'h103, 32'h000000A5, 5'd0, 1, 32'h0);
        run_op(1, 0, 3'd0, 32'h102, 32'h0, 5'd7, 1, 32'h12F03456);
        run_op(1, 0, 3'd4, 32'h102, 32'h0, 5'd9, 1, 32'h12F03456);
        run_op(1, 0, 3'd1, 32'h101, 32'h0, 5'd3, 1, 32'h0);
        run_op(1, 0, 3'd3, 32'h200, 32'h0, 5'd3, 1, 32'h0);
        run_op(1, 1, 3'd2, 32'h204, 32'h0, 5'd3, 1, 32'h0);
        idle_ack();

        // lhu abandoned by reset during REQ, then a late ack.
        @(negedge clk);
        bus.ex_valid = 1'b1;
        bus.ex_mem_read = 1'b1;
        bus.ex_mem_write = 1'b0;
        bus.ex_funct3 = 3'd5;
        bus.ex_addr = 32'h102;
        bus.ex_rd = 5'd12;
        @(negedge clk);
        bus.ex_valid = 1'b0;
        check("mr_req", 32'(bus.dm_req), 1);
        @(negedge clk);
        check("mr_req2", 32'(bus.dm_req), 1);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check_reset_outputs("mr");
        bus.dm_ack = 1'b1;
        bus.dm_rdata = 32'hCAFEF00D;
        @(negedge clk);
        bus.dm_ack = 1'b0;
        check("mr_late_wbv", 32'(bus.wb_valid), 0);
        check("mr_late_busy", 32'(bus.lsu_busy), 0);
        @(negedge clk);
        check("mr_late_wbv2", 32'(bus.wb_valid), 0);
        run_op(1, 0, 3'd2, 32'h300, 32'h0, 5'd4, 2, 32'h89ABCDEF);

        for (int i = 0; i < 300; i++) begin
            int          sel;
            logic [2:0]  f3;
            logic [31:0] a;
            sel = int'($urandom_range(0, 9));
            f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) :
                 ((sel >= 6) ? 3'($urandom_range(0, 2)) :
                  3'(($urandom_range(0, 4) >= 3) ? $urandom_range(4, 5) : $urandom_range(0, 2)));
            a = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'($urandom_range(0, 1) * (f3[1:0] == 2'd0 ? 3 : 2));
            if ($urandom_range(0, 3) == 0) idle_ack();
            run_op(sel == 0 || (sel >= 2 && sel <= 5), sel == 0 || sel >= 6, f3, a, $urandom,
                   5'($urandom), int'($urandom_range(1, 4)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
